mips_mdu: RTL and testbench

Multiply/divide unit for the 5-stage MIPS pipeline. It sits in the execute stage, consumes operands forwarded into E, and owns the architectural HI/LO registers. It services mult/multu/div/divu/madd/maddu/mthi/mtlo/mfhi/mflo. It exports a busy indication that the hazard unit uses to stall any later HI/LO-touching instruction in D.

---
 rtl/mips_mdu_if.sv | 22 ++
 rtl/mips_mdu.sv | 116 +++++++++++
 tb/tb_mips_mdu.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mdu_if.sv
// Execute-stage handshake between the pipeline control/datapath and the MIPS multiply/divide unit.
interface mips_mdu_if;
   logic        start;
   logic [1:0]  mdu_op;
   logic        madd;
   logic        hilo;
   logic        write_enabled;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        busy;
   logic [31:0] rd_data;

   modport master (
      output start, mdu_op, madd, hilo, write_enabled, a_in, b_in,
      input  busy, rd_data
   );

   modport slave (
      input  start, mdu_op, madd, hilo, write_enabled, a_in, b_in,
      output busy, rd_data
   );
endinterface

// File: rtl/mips_mdu.sv
// MIPS multiply/divide unit: owns HI/LO, runs mult/div ops with a fixed busy latency.
// state | meaning
// IDLE  | accepts start or mthi/mtlo
// RUN   | op in flight; counter runs down, result committed when it reaches 0
module mips_mdu #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic       clk,
   input  logic       reset,
   mips_mdu_if.slave  bus
);
   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [1:0]         op_q, op_d;
   logic               madd_q, madd_d;
   logic [63:0]        acc_q, acc_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;

   logic [63:0] prod_s, prod_u, mul_prod, mul_res;
   logic        div_signed, div_zero;
   logic [31:0] a_abs, b_abs, q_abs, r_abs, quot, rem;

   // Sign-extended 64x64 product truncated to 64 bits is the exact signed 32x32 product.
   assign prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u   = {32'd0, a_q} * {32'd0, b_q};
   assign mul_prod = op_q[0] ? prod_u : prod_s;
   assign mul_res  = madd_q ? (acc_q + mul_prod) : mul_prod;

   // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign div_signed = ~op_q[0];
   assign div_zero   = (b_q == 32'd0);
   assign a_abs = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
   assign b_abs = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
   assign q_abs = div_zero ? 32'd0 : (a_abs / b_abs);
   assign r_abs = div_zero ? 32'd0 : (a_abs % b_abs);
   assign quot  = (div_signed && (a_q[31] ^ b_q[31])) ? (~q_abs + 32'd1) : q_abs;
   assign rem   = (div_signed && a_q[31]) ? (~r_abs + 32'd1) : r_abs;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      madd_d  = madd_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a_in;
               b_d     = bus.b_in;
               op_d    = bus.mdu_op;
               madd_d  = bus.madd & ~bus.mdu_op[1];
               acc_d   = {hi_q, lo_q};
               cnt_d   = bus.mdu_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
               state_d = RUN;
            end else if (bus.write_enabled) begin
               if (bus.hilo) hi_d = bus.a_in;
               else          lo_d = bus.a_in;
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               if (op_q[1]) begin
                  if (!div_zero) begin
                     hi_d = rem;
                     lo_d = quot;
                  end
               end else begin
                  hi_d = mul_res[63:32];
                  lo_d = mul_res[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         madd_q  <= 1'b0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         madd_q  <= madd_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy    = (state_q == RUN);
   assign bus.rd_data = bus.hilo ? hi_q : lo_q;
endmodule

// File: tb/tb_mips_mdu.sv
// Directed self-checking bench for mips_mdu: result values, busy latency, ignore rules, async reset.
module tb_mips_mdu;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mips_mdu_if bus ();

   mips_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.start         = 1'b0;
      bus.mdu_op        = 2'b00;
      bus.madd          = 1'b0;
      bus.hilo          = 1'b0;
      bus.write_enabled = 1'b0;
      bus.a_in          = 32'd0;
      bus.b_in          = 32'd0;
   endtask

   // Issues one op and returns how many sampled cycles busy stayed high (bounded).
   task automatic run_op(input logic [1:0] op, input logic md, input logic [31:0] a,
                         input logic [31:0] b, output int n);
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = op; bus.madd = md; bus.a_in = a; bus.b_in = b;
      @(negedge clk);
      idle_inputs();
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      bus.hilo = 1'b1; #1 hi = bus.rd_data;
      bus.hilo = 1'b0; #1 lo = bus.rd_data;
   endtask

   task automatic move_to(input logic sel_hi, input logic [31:0] v);
      @(negedge clk);
      bus.write_enabled = 1'b1; bus.hilo = sel_hi; bus.a_in = v;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset();
      logic [31:0] hi, lo;
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_hilo got %h:%h want 0:0", hi, lo);
      end
   endtask

   task automatic test_mult();
      int n;
      logic [31:0] hi, lo;
      run_op(2'b00, 1'b0, 32'hFFFF_FFFE, 32'd3, n);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL mult_busy_len got %0d want 5", n); end
      bus.hilo = 1'b0; #1;
      checks++;
      if (bus.rd_data !== 32'hFFFF_FFFA) begin
         errors++; $display("FAIL mult_rd_lo got %h want fffffffa", bus.rd_data);
      end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
         errors++; $display("FAIL mult_hilo got %h:%h want ffffffff:fffffffa", hi, lo);
      end
   endtask

   task automatic test_multu_maddu();
      int n;
      logic [31:0] hi, lo;
      run_op(2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         errors++; $display("FAIL multu_hilo got %h:%h want fffffffe:00000001", hi, lo);
      end
      run_op(2'b01, 1'b1, 32'd1, 32'hFFFF_FFFF, n);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL maddu_busy_len got %0d want 5", n); end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'h0000_0000) begin
         errors++; $display("FAIL maddu_hilo got %h:%h want ffffffff:00000000", hi, lo);
      end
   endtask

   task automatic test_div();
      int n;
      logic [31:0] hi, lo;
      run_op(2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, n);
      checks++;
      if (n !== 10) begin errors++; $display("FAIL div_busy_len got %0d want 10", n); end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         errors++; $display("FAIL div_hilo got %h:%h want ffffffff:fffffffd", hi, lo);
      end
      run_op(2'b11, 1'b1, 32'd7, 32'd2, n);
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'd1 || lo !== 32'd3) begin
         errors++; $display("FAIL divu_hilo got %h:%h want 00000001:00000003", hi, lo);
      end
      run_op(2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, n);
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
         errors++; $display("FAIL div_ovf_hilo got %h:%h want 00000000:80000000", hi, lo);
      end
   endtask

   task automatic test_move_divzero();
      int n;
      logic [31:0] hi, lo;
      move_to(1'b0, 32'd1);
      move_to(1'b1, 32'h1234_5678);
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'h1234_5678 || lo !== 32'd1) begin
         errors++; $display("FAIL mthi_hilo got %h:%h want 12345678:00000001", hi, lo);
      end
      run_op(2'b10, 1'b0, 32'd5, 32'd0, n);
      checks++;
      if (n !== 10) begin errors++; $display("FAIL divzero_busy_len got %0d want 10", n); end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'h1234_5678 || lo !== 32'd1) begin
         errors++; $display("FAIL divzero_hilo got %h:%h want 12345678:00000001", hi, lo);
      end
      run_op(2'b00, 1'b1, 32'hFFFF_FFFF, 32'd1, n);
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'h1234_5678 || lo !== 32'd0) begin
         errors++; $display("FAIL madd_hilo got %h:%h want 12345678:00000000", hi, lo);
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      logic [31:0] hi, lo;
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = 2'b00; bus.a_in = 32'd7; bus.b_in = 32'd6;
      @(negedge clk);
      idle_inputs();
      n = 1;
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = 2'b10; bus.a_in = 32'd100; bus.b_in = 32'd3;
      n++;
      @(negedge clk);
      idle_inputs();
      bus.write_enabled = 1'b1; bus.hilo = 1'b0; bus.a_in = 32'h0000_DEAD;
      n++;
      @(negedge clk);
      idle_inputs();
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== 5) begin errors++; $display("FAIL ignore_busy_len got %0d want 5", n); end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'd0 || lo !== 32'h0000_002A) begin
         errors++; $display("FAIL ignore_hilo got %h:%h want 00000000:0000002a", hi, lo);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue busy got %0b want 0", bus.busy); end
   endtask

   task automatic test_async_reset();
      int n;
      logic [31:0] hi, lo;
      @(negedge clk);
      bus.start = 1'b1; bus.mdu_op = 2'b10; bus.a_in = 32'd100; bus.b_in = 32'd7;
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %0b want 0", bus.busy); end
      read_hilo(hi, lo);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL areset_hilo got %h:%h want 0:0", hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      read_hilo(hi, lo);
      checks++;
      if (bus.busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL areset_no_write busy %0b hilo %h:%h want 0 0:0", bus.busy, hi, lo);
      end
      run_op(2'b00, 1'b0, 32'd3, 32'd4, n);
      read_hilo(hi, lo);
      checks++;
      if (n !== 5 || hi !== 32'd0 || lo !== 32'd12) begin
         errors++; $display("FAIL areset_restart len %0d hilo %h:%h want 5 0:c", n, hi, lo);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_mult();
      test_multu_maddu();
      test_div();
      test_move_divzero();
      test_busy_ignore();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
